// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind uart_rx with XON/XOFF flow-control requests for uart_tx.
// The FIFO has no backpressure on the write side, so bytes that arrive while it is full are dropped and flagged.
module uart_rx_fifo #(
    parameter int DEPTH      = 64,
    parameter int HIGH_WATER = 48,
    parameter int LOW_WATER  = 16,
    parameter int FLOW_EN    = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_data,
    input  logic                     i_valid,
    output logic [7:0]               o_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    input  logic                     i_clr_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_HIGH  = (AW+1)'(HIGH_WATER);
    localparam logic [AW:0] C_LOW   = (AW+1)'(LOW_WATER);
    localparam logic [7:0]  C_XON   = 8'h11;
    localparam logic [7:0]  C_XOFF  = 8'h13;

    localparam logic [1:0] S_RUN       = 2'd0;
    localparam logic [1:0] S_SEND_XOFF = 2'd1;
    localparam logic [1:0] S_STOPPED   = 2'd2;
    localparam logic [1:0] S_SEND_XON  = 2'd3;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic [1:0]    r_state;
    logic          r_tx_valid;
    logic [7:0]    r_tx_data;

    logic w_full;
    logic w_nonempty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full     = (r_count == C_DEPTH);
    assign w_nonempty = (r_count != '0);
    assign w_pop      = w_nonempty && i_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign w_push     = i_valid && (!w_full || w_pop);
    assign w_drop     = i_valid && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority over clear so a drop coinciding with a clear is never lost.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_RUN;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            case (r_state)
                S_RUN: begin
                    if ((FLOW_EN != 0) && (r_count >= C_HIGH)) begin
                        r_state    <= S_SEND_XOFF;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= C_XOFF;
                    end
                end
                S_SEND_XOFF: begin
                    if (i_tx_ready) begin
                        r_state    <= S_STOPPED;
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'h00;
                    end
                end
                S_STOPPED: begin
                    if (r_count <= C_LOW) begin
                        r_state    <= S_SEND_XON;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= C_XON;
                    end
                end
                default: begin
                    if (i_tx_ready) begin
                        r_state    <= S_RUN;
                        r_tx_valid <= 1'b0;
                        r_tx_data  <= 8'h00;
                    end
                end
            endcase
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_valid    = w_nonempty;
    assign o_level    = r_count;
    assign o_overflow = r_overflow;
    assign o_tx_valid = r_tx_valid;
    assign o_tx_data  = r_tx_data;

endmodule
